// File: rtl/fp_add_arbiter_pkg.sv
// ============================================================================
// Module  : fp_add_arbiter_pkg
// Brief   : shared widths, tag type and tag helper for the fp_add arbiter
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_add_arbiter_pkg;

  localparam int c_exp   = 8;
  localparam int c_mant  = 23;
  localparam int c_width = 1 + c_exp + c_mant;
  // Tag id is sized for the largest supported requester count (16).
  localparam int c_id_w  = 4;

  typedef struct packed {
    logic              v;
    logic [c_id_w-1:0] id;
  } add_tag_t;

  function automatic add_tag_t make_tag(input logic v, input logic [c_id_w-1:0] id);
    add_tag_t t;
    t.v  = v;
    t.id = v ? id : '0;
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_add_arbiter_if.sv
// ============================================================================
// Module  : fp_add_arbiter_if
// Brief   : requester, adder and response signals of the shared fp_add port
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fp_add_arbiter_if
  import fp_add_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = c_width
) ();

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_dataa;
  logic [N_REQ*WIDTH-1:0] req_datab;
  logic                   add_data_valid;
  logic [WIDTH-1:0]       add_dataa;
  logic [WIDTH-1:0]       add_datab;
  logic                   add_result_valid;
  logic [WIDTH-1:0]       add_result;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_result;
  logic                   err_tag;
  logic                   busy;

  modport slave (
    input  req_valid, req_dataa, req_datab, add_result_valid, add_result,
    output req_ready, add_data_valid, add_dataa, add_datab,
           rsp_valid, rsp_result, err_tag, busy
  );

  modport master (
    output req_valid, req_dataa, req_datab, add_result_valid, add_result,
    input  req_ready, add_data_valid, add_dataa, add_datab,
           rsp_valid, rsp_result, err_tag, busy
  );

endinterface

`default_nettype wire

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : combinational round-robin one-hot grant, priority starting at ptr
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < N; k++) begin
      w_mask[k] = (PTR_W'(k) >= i_ptr);
    end
  end

  // Requests at or above the pointer win; otherwise wrap to the lowest index.
  assign w_hi    = i_req & w_mask;
  assign o_grant = (|w_hi) ? (w_hi & (-w_hi)) : (i_req & (-i_req));

endmodule

`default_nettype wire

// File: rtl/fp_add_arbiter.sv
// ============================================================================
// Module  : fp_add_arbiter
// Brief   : shares one pipelined fp_add between N_REQ requesters, tag-steered
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int EXP     = c_exp,
  parameter int MANT    = c_mant,
  parameter int WIDTH   = 1 + EXP + MANT,
  parameter int ADD_LAT = 4,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic            clock,
  input  logic            clock_sreset,
  fp_add_arbiter_if.slave bus
);

  logic [ID_W-1:0]        r_rr_ptr;
  logic [N_REQ-1:0]       w_grant;
  logic [N_REQ-1:0]       w_ready;
  logic                   w_accept;
  logic [ID_W-1:0]        w_grant_id;
  logic [WIDTH-1:0]       w_sel_a;
  logic [WIDTH-1:0]       w_sel_b;
  logic                   r_add_valid;
  logic [WIDTH-1:0]       r_add_a;
  logic [WIDTH-1:0]       r_add_b;
  add_tag_t               r_issue_tag;
  add_tag_t [ADD_LAT-1:0] r_tag_pipe;
  add_tag_t               w_tail;
  logic [N_REQ-1:0]       w_rsp_onehot;
  logic [N_REQ-1:0]       r_rsp_valid;
  logic [WIDTH-1:0]       r_rsp_result;
  logic                   r_err_tag;
  logic                   w_busy;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (ID_W)
  ) u_rr_arbiter (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  assign w_ready  = clock_sreset ? w_grant : '0;
  assign w_accept = |w_ready;

  always_comb begin
    w_grant_id = '0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_ready[k]) begin
        w_grant_id = ID_W'(k);
        w_sel_a    = bus.req_dataa[k*WIDTH +: WIDTH];
        w_sel_b    = bus.req_datab[k*WIDTH +: WIDTH];
      end
    end
  end

  // The issue tag rides beside add_data_valid, so the pipe tail meets result_valid.
  assign w_tail = r_tag_pipe[ADD_LAT-1];

  always_comb begin
    w_rsp_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_rsp_onehot[k] = w_tail.v && (w_tail.id == c_id_w'(k));
    end
  end

  always_comb begin
    w_busy = r_add_valid;
    for (int k = 0; k < ADD_LAT; k++) begin
      w_busy = w_busy | r_tag_pipe[k].v;
    end
  end

  always_ff @(posedge clock) begin
    if (!clock_sreset) begin
      r_rr_ptr     <= '0;
      r_add_valid  <= 1'b0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_issue_tag  <= '0;
      r_tag_pipe   <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_err_tag    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= (w_grant_id == ID_W'(N_REQ-1)) ? '0 : w_grant_id + ID_W'(1);
      end
      r_add_valid   <= w_accept;
      r_add_a       <= w_sel_a;
      r_add_b       <= w_sel_b;
      r_issue_tag   <= make_tag(w_accept, c_id_w'(w_grant_id));
      r_tag_pipe[0] <= r_issue_tag;
      for (int k = 1; k < ADD_LAT; k++) begin
        r_tag_pipe[k] <= r_tag_pipe[k-1];
      end
      if (bus.add_result_valid && w_tail.v) begin
        r_rsp_valid  <= w_rsp_onehot;
        r_rsp_result <= bus.add_result;
      end else begin
        r_rsp_valid  <= '0;
      end
      if (bus.add_result_valid != w_tail.v) begin
        r_err_tag <= 1'b1;
      end
    end
  end

  assign bus.req_ready      = w_ready;
  assign bus.add_data_valid = r_add_valid;
  assign bus.add_dataa      = r_add_a;
  assign bus.add_datab      = r_add_b;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_result     = r_rsp_result;
  assign bus.err_tag        = r_err_tag;
  assign bus.busy           = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// ============================================================================
// Module  : tb_fp_add_arbiter
// Brief   : random and directed check of fp_add_arbiter against a queue model
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_add_arbiter;

  localparam int N = 4;
  localparam int L = 4;
  localparam int W = 32;

  logic clock = 1'b0;
  logic clock_sreset;
  logic inject;

  always #5 clock = ~clock;

  fp_add_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  fp_add_arbiter #(
    .N_REQ   (N),
    .ADD_LAT (L)
  ) dut (
    .clock        (clock),
    .clock_sreset (clock_sreset),
    .bus          (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Single-precision arithmetic through real; exact for the integer operands used here.
  function automatic real f2r(logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] int2f(int k);
    return r2f($itor(k));
  endfunction

  // Stand-in pipelined adder with fixed latency L, reset together with the arbiter.
  logic [L-1:0]  st_v;
  logic [31:0]   st_d [L];

  always @(posedge clock) begin
    if (!clock_sreset) begin
      st_v <= '0;
      for (int k = 0; k < L; k++) st_d[k] <= 32'd0;
    end else begin
      st_v    <= {st_v[L-2:0], bus.add_data_valid};
      st_d[0] <= fadd(bus.add_dataa, bus.add_datab);
      for (int k = 1; k < L; k++) st_d[k] <= st_d[k-1];
    end
  end

  assign bus.add_result_valid = st_v[L-1] | inject;
  assign bus.add_result       = st_d[L-1];

  // Reference model: round-robin pointer plus a queue of expected responses.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] res;
  } exp_t;

  exp_t        q[$];
  int          edge_cnt  = 0;
  int          m_ptr     = 0;
  logic [31:0] m_last    = 32'd0;
  logic        m_iss_v   = 1'b0;
  logic [31:0] m_iss_a   = 32'd0;
  logic [31:0] m_iss_b   = 32'd0;
  logic        err_model = 1'b0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin : compare
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;
    int           g;
    int           idx;
    exp_rsp = '0;
    if (q.size() > 0 && q[0].due == edge_cnt) begin
      exp_rsp = N'(1) << q[0].id;
      m_last  = q[0].res;
      void'(q.pop_front());
    end
    chk("rsp_valid", bus.rsp_valid, exp_rsp);
    chk("rsp_result", bus.rsp_result, m_last);
    chk("busy", bus.busy, q.size() > 0);
    chk("err_tag", bus.err_tag, err_model);
    chk("add_data_valid", bus.add_data_valid, m_iss_v);
    chk("add_dataa", bus.add_dataa, m_iss_a);
    chk("add_datab", bus.add_datab, m_iss_b);

    exp_rdy = '0;
    g = -1;
    if (clock_sreset) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);

    if (!clock_sreset) begin
      q.delete();
      m_ptr     = 0;
      m_last    = 32'd0;
      m_iss_v   = 1'b0;
      m_iss_a   = 32'd0;
      m_iss_b   = 32'd0;
      err_model = 1'b0;
    end else if (g >= 0) begin
      m_ptr   = (g + 1) % N;
      m_iss_v = 1'b1;
      m_iss_a = bus.req_dataa[g*W +: W];
      m_iss_b = bus.req_datab[g*W +: W];
      q.push_back('{due: edge_cnt + L + 2, id: g, res: fadd(m_iss_a, m_iss_b)});
    end else begin
      m_iss_v = 1'b0;
      m_iss_a = 32'd0;
      m_iss_b = 32'd0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < N; k++) begin
      bus.req_dataa[k*W +: W] = int2f(int'($urandom_range(0, 2000)) - 1000);
      bus.req_datab[k*W +: W] = int2f(int'($urandom_range(0, 2000)) - 1000);
    end
  endtask

  // One op from lane `lane`, then check the response lands exactly L+2 cycles later.
  task automatic single_op(int lane, logic [31:0] a, logic [31:0] b, logic [31:0] sum, string nm);
    logic [N-1:0] oh;
    oh = N'(1) << lane;
    bus.req_dataa[lane*W +: W] = a;
    bus.req_datab[lane*W +: W] = b;
    bus.req_valid = oh;
    #1;
    chk({nm, "_ready"}, bus.req_ready, oh);
    tick();
    bus.req_valid = '0;
    repeat (L) tick();
    chk({nm, "_early"}, bus.rsp_valid, '0);
    tick();
    chk({nm, "_rsp"}, bus.rsp_valid, oh);
    chk({nm, "_sum"}, bus.rsp_result, sum);
  endtask

  initial begin
    clock_sreset  = 1'b0;
    inject        = 1'b0;
    bus.req_valid = '0;
    bus.req_dataa = '0;
    bus.req_datab = '0;
    repeat (3) tick();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rsp", bus.rsp_valid, '0);
    clock_sreset = 1'b1;

    single_op(0, 32'h3f800000, 32'h40000000, 32'h40400000, "t1");
    single_op(2, 32'h41bef920, 32'hc1bef920, 32'h00000000, "t2");

    // Pointer now sits at 3: lane 3 must win over lane 1, then wrap to lane 1.
    randomize_data();
    bus.req_valid = 4'b1010;
    #1;
    chk("t4_first", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = 4'b0010;
    #1;
    chk("t4_wrap", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    repeat (L + 3) tick();

    // All lanes continuously valid from pointer 0.
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      randomize_data();
      #1;
      chk("t3_order", bus.req_ready, N'(1) << (c % N));
      tick();
    end
    bus.req_valid = '0;
    repeat (L + 3) tick();

    repeat (400) begin
      bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
      randomize_data();
      tick();
    end
    bus.req_valid = '0;
    repeat (L + 3) tick();

    // Reset with three operations in flight.
    bus.req_valid = 4'b1111;
    repeat (3) begin
      randomize_data();
      tick();
    end
    bus.req_valid = '0;
    clock_sreset  = 1'b0;
    tick();
    tick();
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_err", bus.err_tag, 1'b0);
    clock_sreset = 1'b1;
    repeat (L + 3) begin
      tick();
      chk("t5_quiet", bus.rsp_valid, '0);
    end
    single_op(1, 32'h40a00000, 32'h40e00000, 32'h41400000, "t5_new");
    repeat (L + 3) tick();

    // Spurious adder result with an empty tag pipe.
    inject = 1'b1;
    #1;
    chk("t6_pre", bus.err_tag, 1'b0);
    tick();
    inject    = 1'b0;
    err_model = 1'b1;
    chk("t6_err", bus.err_tag, 1'b1);
    chk("t6_norsp", bus.rsp_valid, '0);
    repeat (3) begin
      tick();
      chk("t6_sticky", bus.err_tag, 1'b1);
      chk("t6_quiet", bus.rsp_valid, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
